wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Dual-lane write-back stage for the superscalar CPU.
- Registers the MEM/WB pipeline contents for lanes A and B, aligns and extends load data, and selects between the ALU result and the load result.
- Drives the two register-file write ports (rd1/wb_data1/wb_we1 and rd2/wb_data2/wb_we2) that ID_STAGE consumes.
- Also arbitrates same-destination writes and counts retired instructions.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 32, width of the retire counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the WB register contents.
- flush  in  1  squash the WB register contents (both lanes) at the next edge.
- a_valid, b_valid  in  1 each  lane carries a real instruction.
- a_rd, b_rd  in  5 each  destination register.
- a_cntrl, b_cntrl  in  4 each  wb control field:
  - 4'd0 = no write
  - 4'd1 = load writes rd
  - 4'd2 = ALU writes rd
  - other values = no write
- a_alu, b_alu  in  XLEN each  ALU result; for loads this is the effective address.
- a_mem, b_mem  in  XLEN each  raw 32-bit word read from data memory.
- a_funct3, b_funct3  in  3 each  load size/sign.
- rd1, rd2  out  5 each  register-file write address, lane A / lane B.
- wb_data1, wb_data2  out  XLEN each  write data.
- wb_we1, wb_we2  out  4 each  4'd2 = write, 4'd0 = no write.
- retire_cnt  out  CNT_W  count of retired valid instructions.

Behaviour:
- Register update priority, per posedge:
  - rst: all WB register fields and retire_cnt set to 0.
  - else flush: valid, cntrl and rd of both lanes cleared to 0; data fields don't-care, but the bench expects 0.
  - else stall: register and counter hold.
  - else: all lane inputs are captured.
- Latency: an input presented at edge N appears on the write-port outputs after edge N. Outputs are purely combinational from the WB register; no input-to-output combinational path.
- Reset values: rd1 = rd2 = 0, wb_data1 = wb_data2 = 0, wb_we1 = wb_we2 = 0, retire_cnt = 0.
- Per-lane write enable, evaluated on registered values: we_raw = valid && (cntrl == 1 || cntrl == 2) && rd != 0. wb_we = we_raw ? 4'd2 : 4'd0.
- Data select:
  - cntrl == 2: data = alu.
  - cntrl == 1: data = aligned load, with byte offset alu[1:0].
    - LB (000): sign-extend byte mem[8*off+7 : 8*off].
    - LH (001): sign-extend half at offset {off[1], 0}.
    - LW (010): full word.
    - LBU (100): zero-extend byte.
    - LHU (101): zero-extend half.
    - Any other funct3: full word.
  - Otherwise: data = 0.
- Same-destination arbitration: if both lanes have we_raw = 1 and rd1 == rd2, lane A's write is kept and wb_we2 is forced to 0. rd2 and wb_data2 are still driven with lane B values.
- rd == 0 never asserts a write enable.
- retire_cnt increments by the number of registered valid lanes (0, 1 or 2) on each non-stalled, non-flushed, non-reset edge.
  - Lanes with valid = 1 and cntrl = 0 (stores, branches) count as retired.
  - Wraps modulo 2^CNT_W.
  - During stall the counter holds and the held instructions are not re-counted.
- Stall with valid contents: the write ports keep re-presenting the same write every cycle; this is idempotent at the register file.
- Reset asserted mid-operation overrides stall and flush; the outputs read 0 on the cycle after the reset edge.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> all outputs 0, retire_cnt = 0.
- ALU dual write:
  - Stimulus: A {valid, rd = 5, cntrl = 2, alu = 0x1234_5678}; B {valid, rd = 7, cntrl = 2, alu = 0xDEAD_BEEF}.
  - Required next cycle: rd1 = 5, wb_data1 = 0x12345678, wb_we1 = 2; rd2 = 7, wb_data2 = 0xDEADBEEF, wb_we2 = 2; retire_cnt += 2.
- Load alignment, with mem = 0x80FF_7F01:
  - LB, alu = 0x...1 -> wb_data = 0x0000007F.
  - LB, alu = 0x...3 -> wb_data = 0xFFFFFF80.
  - LBU, alu = 0x...2 -> wb_data = 0x000000FF.
  - LH, alu = 0x...2 -> wb_data = 0xFFFF80FF.
  - LHU, alu = 0x...0 -> wb_data = 0x00007F01.
  - LW -> wb_data = 0x80FF7F01.
- Conflict and x0:
  - Both lanes rd = 9, cntrl = 2 -> wb_we1 = 2, wb_we2 = 0.
  - Lane A rd = 0, cntrl = 2 -> wb_we1 = 0, while lane A is still counted as retired.
- Stall/flush:
  - Load a write, then stall 3 cycles with new inputs -> outputs unchanged, retire_cnt unchanged.
  - Assert flush together with stall -> the next cycle shows wb_we1 = wb_we2 = 0, rd = 0.
- Counter wrap: with CNT_W = 4, retire 2 lanes for 8 cycles -> retire_cnt returns to 0 and continues at 2 on the following cycle.

Source files
------------

// File: rtl/wb_stage.sv
// Dual-lane write-back stage: registers MEM/WB contents for lanes A and B,
// aligns/extends load data, drives the two register-file write ports,
// resolves same-destination writes and counts retired instructions.

// Per-lane write-enable qualification and result select / load alignment.
module wb_lane #(
  parameter int XLEN = 32
) (
  input  logic            i_valid,
  input  logic [4:0]      i_rd,
  input  logic [3:0]      i_cntrl,
  input  logic [XLEN-1:0] i_alu,
  input  logic [XLEN-1:0] i_mem,
  input  logic [2:0]      i_funct3,
  output logic            o_we,
  output logic [XLEN-1:0] o_data
);
  logic [1:0]      w_off;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;

  assign w_off = i_alu[1:0];
  assign o_we  = i_valid && (i_cntrl == 4'd1 || i_cntrl == 4'd2) && (i_rd != 5'd0);

  // Pick the addressed byte/half and extend it to XLEN.
  always_comb begin
    w_byte = i_mem[{w_off, 3'b000} +: 8];
    w_half = w_off[1] ? i_mem[16 +: 16] : i_mem[0 +: 16];
    case (i_funct3)
      3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
      default: w_load = i_mem;
    endcase
  end

  // ALU result, aligned load data, or zero for non-writing control codes.
  always_comb begin
    case (i_cntrl)
      4'd2:    o_data = i_alu;
      4'd1:    o_data = w_load;
      default: o_data = '0;
    endcase
  end
endmodule

module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             a_valid,
  input  logic             b_valid,
  input  logic [4:0]       a_rd,
  input  logic [4:0]       b_rd,
  input  logic [3:0]       a_cntrl,
  input  logic [3:0]       b_cntrl,
  input  logic [XLEN-1:0]  a_alu,
  input  logic [XLEN-1:0]  b_alu,
  input  logic [XLEN-1:0]  a_mem,
  input  logic [XLEN-1:0]  b_mem,
  input  logic [2:0]       a_funct3,
  input  logic [2:0]       b_funct3,
  output logic [4:0]       rd1,
  output logic [4:0]       rd2,
  output logic [XLEN-1:0]  wb_data1,
  output logic [XLEN-1:0]  wb_data2,
  output logic [3:0]       wb_we1,
  output logic [3:0]       wb_we2,
  output logic [CNT_W-1:0] retire_cnt
);
  localparam int NUM_LANES = 2;

  // Lane 0 = A, lane 1 = B.
  logic [NUM_LANES-1:0]           r_valid;
  logic [NUM_LANES-1:0][4:0]      r_rd;
  logic [NUM_LANES-1:0][3:0]      r_cntrl;
  logic [NUM_LANES-1:0][XLEN-1:0] r_alu;
  logic [NUM_LANES-1:0][XLEN-1:0] r_mem;
  logic [NUM_LANES-1:0][2:0]      r_funct3;
  logic [CNT_W-1:0]               r_cnt;

  logic [NUM_LANES-1:0]           w_we;
  logic [NUM_LANES-1:0][XLEN-1:0] w_data;
  logic                           w_conflict;

  // WB register: reset > flush > stall > capture.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid  <= '0;
      r_rd     <= '0;
      r_cntrl  <= '0;
      r_alu    <= '0;
      r_mem    <= '0;
      r_funct3 <= '0;
    end else if (!stall) begin
      r_valid  <= {b_valid, a_valid};
      r_rd     <= {b_rd, a_rd};
      r_cntrl  <= {b_cntrl, a_cntrl};
      r_alu    <= {b_alu, a_alu};
      r_mem    <= {b_mem, a_mem};
      r_funct3 <= {b_funct3, a_funct3};
    end
  end

  // Retire the lanes currently held in WB as they leave; a held (stalled)
  // or squashed (flushed) slot is not counted on that edge.
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (!flush && !stall)
      r_cnt <= r_cnt + CNT_W'(r_valid[0]) + CNT_W'(r_valid[1]);
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    wb_lane #(.XLEN(XLEN)) u_lane (
      .i_valid (r_valid[l]),
      .i_rd    (r_rd[l]),
      .i_cntrl (r_cntrl[l]),
      .i_alu   (r_alu[l]),
      .i_mem   (r_mem[l]),
      .i_funct3(r_funct3[l]),
      .o_we    (w_we[l]),
      .o_data  (w_data[l])
    );
  end

  // Same destination in both lanes: lane A (older) wins, B's enable drops.
  assign w_conflict = w_we[0] && w_we[1] && (r_rd[0] == r_rd[1]);

  assign rd1        = r_rd[0];
  assign rd2        = r_rd[1];
  assign wb_data1   = w_data[0];
  assign wb_data2   = w_data[1];
  assign wb_we1     = w_we[0] ? 4'd2 : 4'd0;
  assign wb_we2     = (w_we[1] && !w_conflict) ? 4'd2 : 4'd0;
  assign retire_cnt = r_cnt;
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage (CNT_W = 4 so the counter wrap is reachable).
module tb_wb_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic [3:0]  c;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [2:0]  f3;
  } lane_t;

  typedef struct packed {
    logic [4:0]       rd1;
    logic [31:0]      d1;
    logic [3:0]       we1;
    logic [4:0]       rd2;
    logic [31:0]      d2;
    logic [3:0]       we2;
    logic [CNT_W-1:0] cnt;
  } out_t;

  logic clk = 1'b0;
  logic rst, stall, flush;
  lane_t la, lb;
  logic [4:0] rd1, rd2;
  logic [31:0] wb_data1, wb_data2;
  logic [3:0] wb_we1, wb_we2;
  logic [CNT_W-1:0] retire_cnt;
  out_t o_act;

  int n_chk = 0;
  int n_fail = 0;

  lane_t m_a, m_b;
  logic [CNT_W-1:0] m_cnt;
  out_t q[$];

  always #5 clk = ~clk;

  wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .a_valid(la.v), .b_valid(lb.v), .a_rd(la.rd), .b_rd(lb.rd),
    .a_cntrl(la.c), .b_cntrl(lb.c), .a_alu(la.alu), .b_alu(lb.alu),
    .a_mem(la.mem), .b_mem(lb.mem), .a_funct3(la.f3), .b_funct3(lb.f3),
    .rd1(rd1), .rd2(rd2), .wb_data1(wb_data1), .wb_data2(wb_data2),
    .wb_we1(wb_we1), .wb_we2(wb_we2), .retire_cnt(retire_cnt)
  );

  assign o_act = {rd1, wb_data1, wb_we1, rd2, wb_data2, wb_we2, retire_cnt};

  function automatic lane_t mk(input logic v, input logic [4:0] rd, input logic [3:0] c,
                               input logic [31:0] alu, input logic [31:0] mem, input logic [2:0] f3);
    lane_t l;
    l.v = v; l.rd = rd; l.c = c; l.alu = alu; l.mem = mem; l.f3 = f3;
    return l;
  endfunction

  function automatic lane_t rnd();
    return mk(1'($urandom), 5'($urandom), 4'($urandom_range(0, 3)), $urandom, $urandom, 3'($urandom));
  endfunction

  function automatic logic [31:0] m_data(input lane_t l);
    logic [7:0] by;
    logic [15:0] h;
    by = 8'(l.mem >> (8 * l.alu[1:0]));
    h  = l.alu[1] ? l.mem[31:16] : l.mem[15:0];
    if (l.c == 4'd2) return l.alu;
    if (l.c != 4'd1) return 32'h0;
    case (l.f3)
      3'b000:  return {{24{by[7]}}, by};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, by};
      3'b101:  return {16'h0, h};
      default: return l.mem;
    endcase
  endfunction

  function automatic out_t m_out();
    out_t o;
    logic wa, wb;
    wa = m_a.v && (m_a.c == 4'd1 || m_a.c == 4'd2) && m_a.rd != 5'd0;
    wb = m_b.v && (m_b.c == 4'd1 || m_b.c == 4'd2) && m_b.rd != 5'd0;
    o.rd1 = m_a.rd; o.d1 = m_data(m_a); o.we1 = wa ? 4'd2 : 4'd0;
    o.rd2 = m_b.rd; o.d2 = m_data(m_b);
    o.we2 = (wb && !(wa && m_a.rd == m_b.rd)) ? 4'd2 : 4'd0;
    o.cnt = m_cnt;
    return o;
  endfunction

  // Drive one cycle, advance the model, queue the expected outputs.
  task automatic cyc(input logic r, input logic f, input logic s, input lane_t a, input lane_t b);
    rst = r; flush = f; stall = s; la = a; lb = b;
    if (r) begin
      m_a = '0; m_b = '0; m_cnt = '0;
    end else if (f) begin
      m_a = '0; m_b = '0;
    end else if (!s) begin
      m_cnt = m_cnt + CNT_W'(m_a.v) + CNT_W'(m_b.v);
      m_a = a; m_b = b;
    end
    q.push_back(m_out());
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    out_t e;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'($urandom), 1'($urandom), rnd(), rnd());
      e = q.pop_front();
      n_chk++;
      if (o_act !== e || o_act !== '0) begin
        n_fail++;
        $display("FAIL reset_%0d got=%h exp=%h", i, o_act, e);
      end
    end
  endtask

  task automatic test_alu_dual();
    out_t e;
    cyc(0, 0, 0, mk(1, 5'd5, 4'd2, 32'h1234_5678, $urandom, 3'd0),
                 mk(1, 5'd7, 4'd2, 32'hDEAD_BEEF, $urandom, 3'd0));
    e = q.pop_front();
    n_chk++;
    if (o_act !== e || wb_data1 !== 32'h1234_5678 || wb_data2 !== 32'hDEAD_BEEF ||
        wb_we1 !== 4'd2 || wb_we2 !== 4'd2 || rd1 !== 5'd5 || rd2 !== 5'd7) begin
      n_fail++;
      $display("FAIL alu_dual got=%h exp=%h", o_act, e);
    end
    cyc(0, 0, 0, '0, '0);
    e = q.pop_front();
    n_chk++;
    if (o_act !== e || retire_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL alu_dual_retire got=%h exp=%h", o_act, e);
    end
  endtask

  task automatic test_load();
    out_t e;
    logic [2:0]  f3s [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  offs[6] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd0};
    logic [31:0] want[6] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_00FF,
                             32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, mk(1, 5'd3, 4'd1, {30'h0400_0000, offs[i]}, 32'h80FF_7F01, f3s[i]), rnd());
      e = q.pop_front();
      n_chk++;
      if (o_act !== e || wb_data1 !== want[i] || wb_we1 !== 4'd2) begin
        n_fail++;
        $display("FAIL load_%0d got=%h exp=%h data=%h want=%h", i, o_act, e, wb_data1, want[i]);
      end
    end
  endtask

  task automatic test_conflict();
    out_t e;
    cyc(0, 0, 0, mk(1, 5'd9, 4'd2, 32'h1111_1111, 0, 0), mk(1, 5'd9, 4'd2, 32'h2222_2222, 0, 0));
    e = q.pop_front();
    n_chk++;
    if (o_act !== e || wb_we1 !== 4'd2 || wb_we2 !== 4'd0 || wb_data2 !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL conflict got=%h exp=%h", o_act, e);
    end
    cyc(0, 0, 0, mk(1, 5'd0, 4'd2, 32'h3333_3333, 0, 0), '0);
    e = q.pop_front();
    n_chk++;
    if (o_act !== e || wb_we1 !== 4'd0) begin
      n_fail++;
      $display("FAIL x0_no_write got=%h exp=%h", o_act, e);
    end
    cyc(0, 0, 0, '0, '0);
    e = q.pop_front();
    n_chk++;
    if (o_act !== e) begin
      n_fail++;
      $display("FAIL x0_retired got=%h exp=%h", o_act, e);
    end
  endtask

  task automatic test_stall_flush();
    out_t e, held;
    cyc(0, 0, 0, mk(1, 5'd4, 4'd2, 32'hCAFE_F00D, 0, 0), mk(1, 5'd6, 4'd0, 32'h5, 0, 0));
    held = q.pop_front();
    n_chk++;
    if (o_act !== held) begin
      n_fail++;
      $display("FAIL stall_load got=%h exp=%h", o_act, held);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, rnd(), rnd());
      e = q.pop_front();
      n_chk++;
      if (o_act !== e || o_act !== held) begin
        n_fail++;
        $display("FAIL stall_hold_%0d got=%h exp=%h", i, o_act, held);
      end
    end
    cyc(0, 1, 1, rnd(), rnd());
    e = q.pop_front();
    n_chk++;
    if (o_act !== e || wb_we1 !== 4'd0 || wb_we2 !== 4'd0 || rd1 !== 5'd0 || rd2 !== 5'd0 ||
        retire_cnt !== held.cnt) begin
      n_fail++;
      $display("FAIL flush got=%h exp=%h", o_act, e);
    end
  endtask

  task automatic test_wrap();
    out_t e;
    cyc(1, 0, 0, '0, '0);
    void'(q.pop_front());
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, mk(1, 5'd1, 4'd0, 0, 0, 0), mk(1, 5'd2, 4'd0, 0, 0, 0));
      e = q.pop_front();
      n_chk++;
      if (o_act !== e || (i == 8 && retire_cnt !== 4'd0) || (i == 9 && retire_cnt !== 4'd2) ||
          (i == 4 && retire_cnt !== 4'd8)) begin
        n_fail++;
        $display("FAIL wrap_%0d got=%h exp=%h cnt=%0d", i, o_act, e, retire_cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; la = '0; lb = '0;
    m_a = '0; m_b = '0; m_cnt = '0;
    test_reset();
    test_alu_dual();
    test_load();
    test_conflict();
    test_stall_flush();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
